// File: rtl/ccu_txn_arbiter.sv
// Round-robin AR/AW request arbiter in front of the single-transaction CCU FSM.
// Optional BUSY watchdog is enabled by defining CCU_ARB_WATCHDOG_EN.
module ccu_txn_arbiter #(
  parameter int unsigned NoMstPorts    = 4,
  parameter int unsigned IdxW          = $clog2(NoMstPorts),
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NoMstPorts-1:0] ar_valid_i,
  input  logic [NoMstPorts-1:0] aw_valid_i,
  output logic [NoMstPorts-1:0] ar_ready_o,
  output logic [NoMstPorts-1:0] aw_ready_o,
  output logic                  ccu_ar_valid_o,
  output logic                  ccu_aw_valid_o,
  input  logic                  ccu_ar_ready_i,
  input  logic                  ccu_aw_ready_i,
  output logic [IdxW-1:0]       sel_o,
  output logic                  sel_is_write_o,
  input  logic                  txn_done_i,
  output logic                  busy_o,
  output logic                  timeout_o
);

  localparam int unsigned NumLines = 2 * NoMstPorts;
  localparam int unsigned LineW    = IdxW + 1;

  if (NoMstPorts < 2) begin : g_bad_ports
    $error("ccu_txn_arbiter: NoMstPorts must be at least 2");
  end
  if (TimeoutCycles < 2) begin : g_bad_timeout
    $error("ccu_txn_arbiter: TimeoutCycles must be at least 2");
  end

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    BUSY
  } state_e;

  state_e              state_q, state_d;
  logic [LineW-1:0]    rr_q, rr_d;
  logic [IdxW-1:0]     sel_q, sel_d;
  logic                is_write_q, is_write_d;

  logic [NumLines-1:0] req;
  logic                found;
  logic [LineW-1:0]    win;
  logic                handshake;
  logic                expire;

  // Line 2i is master i AR, line 2i+1 is master i AW.
  always_comb begin
    req = '0;
    for (int unsigned i = 0; i < NoMstPorts; i++) begin
      req[2*i]   = ar_valid_i[i];
      req[2*i+1] = aw_valid_i[i];
    end
  end

  // First valid line at or after the round-robin pointer, wrapping.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned off = 0; off < NumLines; off++) begin
      idx = (int'(rr_q) + off) % NumLines;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = LineW'(idx);
      end
    end
  end

  assign handshake = is_write_q ? ccu_aw_ready_i : ccu_ar_ready_i;

`ifdef CCU_ARB_WATCHDOG_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Held at zero outside BUSY, so it starts from zero on every BUSY entry.
  always_comb begin
    cnt_d = '0;
    if (state_q == BUSY) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (state_q == BUSY) && (cnt_q == CntW'(TimeoutCycles - 1)) && !txn_done_i;
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      rr_q       <= '0;
      sel_q      <= '0;
      is_write_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      sel_q      <= sel_d;
      is_write_q <= is_write_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    sel_d      = sel_q;
    is_write_d = is_write_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = FWD;
          sel_d      = win[LineW-1:1];
          is_write_d = win[0];
          rr_d       = (win == LineW'(NumLines - 1)) ? '0 : win + LineW'(1);
        end
      end
      FWD: begin
        if (handshake) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (txn_done_i || expire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ar_ready_o     = '0;
    aw_ready_o     = '0;
    ccu_ar_valid_o = (state_q == FWD) && !is_write_q;
    ccu_aw_valid_o = (state_q == FWD) && is_write_q;
    busy_o         = (state_q != IDLE);
    timeout_o      = expire;
    if (ccu_ar_valid_o) begin
      ar_ready_o[sel_q] = ccu_ar_ready_i;
    end
    if (ccu_aw_valid_o) begin
      aw_ready_o[sel_q] = ccu_aw_ready_i;
    end
  end

  assign sel_o          = sel_q;
  assign sel_is_write_o = is_write_q;

endmodule

// File: tb/tb_ccu_txn_arbiter.sv
// Directed self-checking bench for ccu_txn_arbiter (NoMstPorts=4, TimeoutCycles=16).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_ccu_txn_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ar_valid, aw_valid;
  logic [3:0] ar_ready, aw_ready;
  logic       ccu_ar_valid, ccu_aw_valid;
  logic       ccu_ar_ready, ccu_aw_ready;
  logic [1:0] sel;
  logic       sel_is_write;
  logic       txn_done;
  logic       busy;
  logic       timeout;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  ccu_txn_arbiter #(
    .NoMstPorts   (4),
    .TimeoutCycles(16)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .ar_valid_i    (ar_valid),
    .aw_valid_i    (aw_valid),
    .ar_ready_o    (ar_ready),
    .aw_ready_o    (aw_ready),
    .ccu_ar_valid_o(ccu_ar_valid),
    .ccu_aw_valid_o(ccu_aw_valid),
    .ccu_ar_ready_i(ccu_ar_ready),
    .ccu_aw_ready_i(ccu_aw_ready),
    .sel_o         (sel),
    .sel_is_write_o(sel_is_write),
    .txn_done_i    (txn_done),
    .busy_o        (busy),
    .timeout_o     (timeout)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    ar_valid = '0; aw_valid = '0; ccu_ar_ready = 0; ccu_aw_ready = 0; txn_done = 0;
    rst = 1; step(); step(); rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({busy, timeout, ccu_ar_valid, ccu_aw_valid, ar_ready, aw_ready, sel, sel_is_write} !== 14'b0)
      $display("FAIL reset_outputs: got busy=%b to=%b arv=%b awv=%b arr=%b awr=%b sel=%0d w=%b, want all 0",
               busy, timeout, ccu_ar_valid, ccu_aw_valid, ar_ready, aw_ready, sel, sel_is_write);
    else n_pass++;
  endtask

  // rr: 0 -> 5
  task automatic test_single_ar();
    ar_valid = 4'b0100;
    step();
    n_checks++;
    if ({sel, sel_is_write, ccu_ar_valid, ccu_aw_valid, busy} !== {2'd2, 1'b0, 1'b1, 1'b0, 1'b1})
      $display("FAIL single_grant: got sel=%0d w=%b arv=%b awv=%b busy=%b, want sel=2 w=0 arv=1 awv=0 busy=1",
               sel, sel_is_write, ccu_ar_valid, ccu_aw_valid, busy);
    else n_pass++;
    n_checks++;
    if (ar_ready !== 4'b0000) $display("FAIL single_ready_low: got %b want 0000", ar_ready);
    else n_pass++;
    ccu_ar_ready = 1; #1;
    n_checks++;
    if ({ar_ready, aw_ready} !== 8'b0100_0000)
      $display("FAIL single_ready: got ar=%b aw=%b want ar=0100 aw=0000", ar_ready, aw_ready);
    else n_pass++;
    step();
    n_checks++;
    if ({ar_ready, ccu_ar_valid, busy} !== {4'b0000, 1'b0, 1'b1})
      $display("FAIL single_busy: got arr=%b arv=%b busy=%b want 0000 0 1", ar_ready, ccu_ar_valid, busy);
    else n_pass++;
    ar_valid = '0; ccu_ar_ready = 0;
    step(); step();
    n_checks++;
    if (busy !== 1'b1) $display("FAIL single_wait_done: got busy=%b want 1", busy);
    else n_pass++;
    txn_done = 1; step(); txn_done = 0;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL single_done_idle: got busy=%b want 0", busy);
    else n_pass++;
  endtask

  // rr: 5 -> 4 (M1 AW, line 3)
  task automatic test_done_ignored();
    txn_done = 1; step(); txn_done = 0;
    n_checks++;
    if ({busy, ccu_ar_valid, ccu_aw_valid} !== 3'b000)
      $display("FAIL done_in_idle: got busy=%b arv=%b awv=%b want 000", busy, ccu_ar_valid, ccu_aw_valid);
    else n_pass++;
    aw_valid = 4'b0010;
    step();
    txn_done = 1; step(); txn_done = 0;
    n_checks++;
    if ({ccu_aw_valid, sel, sel_is_write, busy} !== {1'b1, 2'd1, 1'b1, 1'b1})
      $display("FAIL done_in_fwd: got awv=%b sel=%0d w=%b busy=%b want awv=1 sel=1 w=1 busy=1",
               ccu_aw_valid, sel, sel_is_write, busy);
    else n_pass++;
    ccu_aw_ready = 1; step(); aw_valid = '0; ccu_aw_ready = 0;
    txn_done = 1; step(); txn_done = 0;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL done_in_fwd_finish: got busy=%b want 0", busy);
    else n_pass++;
  endtask

  // rr: 4 -> line 7 (M3 AW) wins over M0/M1 AR, rr wraps to 0
  task automatic test_stall();
    bit bad = 0;
    aw_valid = 4'b1000; ar_valid = 4'b0011;
    step();
    for (int i = 0; i < 10; i++) begin
      if ({ccu_aw_valid, ccu_ar_valid, sel, sel_is_write, aw_ready, ar_ready} !== {1'b1, 1'b0, 2'd3, 1'b1, 8'h00})
        bad = 1;
      step();
    end
    n_checks++;
    if (bad) $display("FAIL stall_hold: got awv=%b arv=%b sel=%0d w=%b awr=%b arr=%b want 1 0 3 1 0000 0000",
                      ccu_aw_valid, ccu_ar_valid, sel, sel_is_write, aw_ready, ar_ready);
    else n_pass++;
    ccu_aw_ready = 1; #1;
    n_checks++;
    if (aw_ready !== 4'b1000) $display("FAIL stall_release: got aw_ready=%b want 1000", aw_ready);
    else n_pass++;
    step(); aw_valid = '0; ccu_aw_ready = 0;
    txn_done = 1; step(); txn_done = 0;
    step();
    n_checks++;
    if ({sel, sel_is_write, ccu_ar_valid} !== {2'd0, 1'b0, 1'b1})
      $display("FAIL stall_wrap: got sel=%0d w=%b arv=%b want sel=0 w=0 arv=1", sel, sel_is_write, ccu_ar_valid);
    else n_pass++;
  endtask

  // Continues from M0 AR in FWD with rr=1; reset must bring rr back to 0.
  task automatic test_reset_in_busy();
    ccu_ar_ready = 1; step(); ccu_ar_ready = 0;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL rst_pre_busy: got busy=%b want 1", busy);
    else n_pass++;
    rst = 1; step(); rst = 0;
    n_checks++;
    if ({busy, ccu_ar_valid, ccu_aw_valid} !== 3'b000)
      $display("FAIL rst_in_busy: got busy=%b arv=%b awv=%b want 000", busy, ccu_ar_valid, ccu_aw_valid);
    else n_pass++;
    step();
    n_checks++;
    if ({sel, sel_is_write, ccu_ar_valid} !== {2'd0, 1'b0, 1'b1})
      $display("FAIL rst_rr_zero: got sel=%0d w=%b arv=%b want sel=0 w=0 arv=1", sel, sel_is_write, ccu_ar_valid);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_round_robin();
    bit granted;
    do_reset();
    ar_valid = 4'hF; aw_valid = 4'hF; ccu_ar_ready = 1; ccu_aw_ready = 1;
    for (int k = 0; k < 10; k++) begin
      int exp_line;
      exp_line = k % 8;
      granted = 0;
      for (int w = 0; w < 20 && !granted; w++) begin
        if (ccu_ar_valid || ccu_aw_valid) granted = 1;
        else step();
      end
      n_checks++;
      if (!granted) $display("FAIL rr_grant_%0d: got no grant within 20 cycles, want line %0d", k, exp_line);
      else if ({sel, sel_is_write} !== 3'(exp_line))
        $display("FAIL rr_order_%0d: got sel=%0d w=%b want sel=%0d w=%0d", k, sel, sel_is_write,
                 exp_line / 2, exp_line % 2);
      else n_pass++;
      step(); step(); step();
      txn_done = 1; step(); txn_done = 0;
    end
    do_reset();
  endtask

  task automatic test_watchdog();
    bit bad = 0;
    do_reset();
    ar_valid = 4'b0001; ccu_ar_ready = 1;
    step(); step();
    ar_valid = '0; ccu_ar_ready = 0;
`ifdef CCU_ARB_WATCHDOG_EN
    for (int i = 1; i < 16; i++) begin
      if ({busy, timeout} !== 2'b10) bad = 1;
      step();
    end
    n_checks++;
    if (bad) $display("FAIL wd_early: got busy=%b timeout=%b before cycle 16, want busy=1 timeout=0", busy, timeout);
    else n_pass++;
    n_checks++;
    if ({busy, timeout} !== 2'b11) $display("FAIL wd_fire: got busy=%b timeout=%b want 1 1", busy, timeout);
    else n_pass++;
    step();
    n_checks++;
    if ({busy, timeout} !== 2'b00) $display("FAIL wd_idle: got busy=%b timeout=%b want 0 0", busy, timeout);
    else n_pass++;
`else
    for (int i = 0; i < 100; i++) begin
      if ({busy, timeout} !== 2'b10) bad = 1;
      step();
    end
    n_checks++;
    if (bad) $display("FAIL no_wd_busy: got busy=%b timeout=%b want busy=1 timeout=0 for 100 cycles", busy, timeout);
    else n_pass++;
`endif
    do_reset();
  endtask

  initial begin
    test_reset();
    test_single_ar();
    test_done_ignored();
    test_stall();
    test_reset_in_busy();
    test_round_robin();
    test_watchdog();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running, want finish");
    $fatal(1);
  end

endmodule
